// File: rtl/doodle_sprite_draw.sv
// Doodle sprite hit-test: latches the physics position once per frame at the VSYNC falling edge,
// then emits a 2-cycle pipelined sprite-ROM address and doodle_on. Optional macro: DOODLE_SPRITE_MIRROR_EN.
module doodle_sprite_draw #(
  parameter int RESET_X   = 320,
  parameter int RESET_Y   = 240,
  parameter int RESET_S   = 12,
  parameter int MAX_S     = 16,
  parameter int BLINK_BIT = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       VGA_VS,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] DoodleX,
  input  logic [9:0] DoodleY,
  input  logic [9:0] DoodleS,
  input  logic [2:0] outstate,
  output logic [9:0] sprite_addr,
  output logic       doodle_on,
  output logic       facing_left
);

  localparam logic [2:0] ST_OVER = 3'b010;
  localparam logic [9:0] MAX_S_V = MAX_S[9:0];

  typedef enum logic {FACE_RIGHT, FACE_LEFT} face_e;

  logic        vs_q;
  logic [9:0]  sx_q, sy_q, ss_q;
  logic [2:0]  st_q;
  logic [7:0]  blink_q;
  face_e       face_q;

  logic        hit1_q;
  logic [4:0]  row1_q, col1_q;
  logic [9:0]  sprite_addr_q;
  logic        doodle_on_q;

  logic        frame_start;
  logic [9:0]  s_new;
  logic signed [10:0] d;
  logic [10:0] abs_d;
  logic        wrap_jump;

  assign frame_start = vs_q & ~VGA_VS;
  assign s_new       = (DoodleS > MAX_S_V) ? MAX_S_V : DoodleS;
  assign d           = $signed({1'b0, DoodleX}) - $signed({1'b0, sx_q});
  assign abs_d       = d[10] ? 11'(-d) : 11'(d);
  // A jump bigger than four half-sizes is a screen wrap, not real motion.
  assign wrap_jump   = {1'b0, abs_d} > {s_new, 2'b00};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vs_q    <= 1'b1;
      sx_q    <= RESET_X[9:0];
      sy_q    <= RESET_Y[9:0];
      ss_q    <= RESET_S[9:0];
      st_q    <= 3'b000;
      blink_q <= 8'd0;
    end else begin
      vs_q <= VGA_VS;
      if (frame_start) begin
        sx_q <= DoodleX;
        sy_q <= DoodleY;
        ss_q <= s_new;
        st_q <= outstate;
        if (outstate != ST_OVER)  blink_q <= 8'd0;
        else if (st_q == ST_OVER) blink_q <= blink_q + 8'd1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      face_q <= FACE_RIGHT;
    end else if (frame_start && !wrap_jump) begin
      if (d[10])          face_q <= FACE_LEFT;
      else if (d != '0)   face_q <= FACE_RIGHT;
    end
  end

  assign facing_left = (face_q == FACE_LEFT);

  // Stage 1: box test in 12-bit signed space so boxes past the left/top edge clip instead of wrapping.
  logic [11:0] left_d, top_d, dx_d, dy_d, size_d;
  logic        hit_d;
  logic [4:0]  col_d;

  assign left_d = {2'b00, sx_q} - {2'b00, ss_q};
  assign top_d  = {2'b00, sy_q} - {2'b00, ss_q};
  assign dx_d   = {2'b00, DrawX} - left_d;
  assign dy_d   = {2'b00, DrawY} - top_d;
  assign size_d = {1'b0, ss_q, 1'b0};
  assign hit_d  = !dx_d[11] && (dx_d < size_d) && !dy_d[11] && (dy_d < size_d);

`ifdef DOODLE_SPRITE_MIRROR_EN
  logic [11:0] mcol_d;
  assign mcol_d = size_d - 12'd1 - dx_d;
  assign col_d  = (face_q == FACE_LEFT) ? mcol_d[4:0] : dx_d[4:0];
`else
  assign col_d  = dx_d[4:0];
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hit1_q <= 1'b0;
      row1_q <= 5'd0;
      col1_q <= 5'd0;
    end else begin
      hit1_q <= hit_d;
      row1_q <= dy_d[4:0];
      col1_q <= col_d;
    end
  end

  // Stage 2: blink gating; address only advances on a drawn pixel.
  logic visible;
  assign visible = !((st_q == ST_OVER) && blink_q[BLINK_BIT]);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sprite_addr_q <= 10'd0;
      doodle_on_q   <= 1'b0;
    end else begin
      doodle_on_q <= hit1_q & visible;
      if (hit1_q & visible) sprite_addr_q <= {row1_q, col1_q};
    end
  end

  assign sprite_addr = sprite_addr_q;
  assign doodle_on   = doodle_on_q;

endmodule

// File: tb/tb_doodle_sprite_draw.sv
// Bench for doodle_sprite_draw: constant vector table, directed frame sequences and
// randomized pixel streams checked against a frame-level behavioural model.
module tb_doodle_sprite_draw;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       VGA_VS;
  logic [9:0] DrawX, DrawY, DoodleX, DoodleY, DoodleS;
  logic [2:0] outstate;
  logic [9:0] sprite_addr;
  logic       doodle_on, facing_left;

  int n_cmp = 0;
  int n_fail = 0;

  // Frame-level model state
  int m_sx, m_sy, m_ss, m_st, m_cnt;
  bit m_face;

`ifdef DOODLE_SPRITE_MIRROR_EN
  localparam bit MIRROR = 1'b1;
`else
  localparam bit MIRROR = 1'b0;
`endif

  doodle_sprite_draw dut (
    .Clk(Clk), .Reset(Reset), .VGA_VS(VGA_VS),
    .DrawX(DrawX), .DrawY(DrawY),
    .DoodleX(DoodleX), .DoodleY(DoodleY), .DoodleS(DoodleS),
    .outstate(outstate),
    .sprite_addr(sprite_addr), .doodle_on(doodle_on), .facing_left(facing_left)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int x;
    int y;
    bit on;
    int addr;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_sx = 320; m_sy = 240; m_ss = 12; m_st = 0; m_cnt = 0; m_face = 1'b0;
  endfunction

  function automatic void model_frame(input int x, input int y, input int s, input int st);
    int dd, sn;
    sn = (s > 16) ? 16 : s;
    dd = x - m_sx;
    if (!((dd < 0 ? -dd : dd) > 4 * sn)) begin
      if (dd > 0) m_face = 1'b0;
      else if (dd < 0) m_face = 1'b1;
    end
    if (st != 2) m_cnt = 0;
    else if (m_st == 2) m_cnt = (m_cnt + 1) % 256;
    m_sx = x; m_sy = y; m_ss = sn; m_st = st;
  endfunction

  function automatic void model_pix(input int px, input int py, output bit on, output int addr);
    int dx, dy, col;
    bit hit, vis;
    dx  = px - (m_sx - m_ss);
    dy  = py - (m_sy - m_ss);
    hit = (dx >= 0) && (dx < 2 * m_ss) && (dy >= 0) && (dy < 2 * m_ss);
    vis = !(m_st == 2 && ((m_cnt / 8) % 2 == 1));
    col = (MIRROR && m_face) ? (2 * m_ss - 1 - dx) : dx;
    on   = hit && vis;
    addr = ((dy % 32) * 32) + (col % 32);
  endfunction

  // Pulse VSYNC low for one clock with new physics values.
  task automatic frame(input int x, input int y, input int s, input int st);
    VGA_VS = 1'b0;
    DoodleX = 10'(x); DoodleY = 10'(y); DoodleS = 10'(s); outstate = 3'(st);
    @(posedge Clk); #1;
    VGA_VS = 1'b1;
    @(posedge Clk); #1;
    model_frame(x, y, s, st);
  endtask

  task automatic pix(input int x, input int y, output bit on, output int addr);
    DrawX = 10'(x); DrawY = 10'(y);
    repeat (2) @(posedge Clk);
    #1;
    on = doodle_on; addr = int'(sprite_addr);
  endtask

  task automatic pix_const(input string name, input int x, input int y, input bit eon, input int eaddr);
    bit on; int addr;
    pix(x, y, on, addr);
    chk({name, ".on"}, on, eon);
    if (eon) chk({name, ".addr"}, addr, eaddr);
  endtask

  task automatic pix_model(input string name, input int x, input int y);
    bit on, eon; int addr, eaddr;
    pix(x, y, on, addr);
    model_pix(x, y, eon, eaddr);
    chk({name, ".on"}, on, eon);
    if (eon) chk({name, ".addr"}, addr, eaddr);
  endtask

  vec_t tbl[6];

  initial begin
    bit eon_q[$];
    int eaddr_q[$];

    tbl[0] = '{308, 228, 1'b1, 0};
    tbl[1] = '{332, 240, 1'b0, 0};
    tbl[2] = '{331, 251, 1'b1, 23 * 32 + 23};
    tbl[3] = '{307, 228, 1'b0, 0};
    tbl[4] = '{308, 227, 1'b0, 0};
    tbl[5] = '{320, 240, 1'b1, 12 * 32 + 12};

    Reset = 1'b1; VGA_VS = 1'b1;
    DrawX = '0; DrawY = '0; DoodleX = '0; DoodleY = '0; DoodleS = '0; outstate = '0;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    chk("reset.doodle_on", int'(doodle_on), 0);
    chk("reset.sprite_addr", int'(sprite_addr), 0);
    chk("reset.facing_left", int'(facing_left), 0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    // Reset position is drawn before any frame strobe
    pix_const("prefr", 308, 228, 1'b1, 0);

    frame(320, 240, 12, 1);
    for (int i = 0; i < 6; i++) pix_const($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y, tbl[i].on, tbl[i].addr);

    // Mid-frame input changes must not move the box
    DoodleX = 10'd400;
    repeat (4) @(posedge Clk);
    #1;
    pix_const("notear.old", 308, 228, 1'b1, 0);
    pix_const("notear.new", 388, 228, 1'b0, 0);
    frame(400, 240, 12, 1);
    pix_const("vsfall.new", 388, 228, 1'b1, 0);

    // Facing: 400->320 is a wrap (|d|=80>48), 320->318 left, 318->620 wrap, 620->630 right
    frame(320, 240, 12, 1);
    chk("face.wrap1", int'(facing_left), 0);
    frame(318, 240, 12, 1);
    chk("face.left", int'(facing_left), 1);
    frame(620, 240, 12, 1);
    chk("face.hold", int'(facing_left), 1);
    pix_const("mirror", 608, 228, 1'b1, MIRROR ? 23 : 0);
    frame(630, 240, 12, 1);
    chk("face.right", int'(facing_left), 0);

    // Game-over blink: hidden while counter bit 3 is set
    for (int k = 0; k < 16; k++) begin
      frame(320, 240, 12, 2);
      pix_const($sformatf("blink%0d", k), 320, 240, k < 8, 12 * 32 + 12);
    end
    frame(320, 240, 12, 1);
    pix_const("play.vis", 320, 240, 1'b1, 12 * 32 + 12);
    frame(320, 240, 12, 2);
    pix_const("over.cnt0", 320, 240, 1'b1, 12 * 32 + 12);

    // Left-edge clipping, no wrap to the right edge
    frame(5, 240, 12, 1);
    for (int x = 0; x <= 17; x++) pix_const($sformatf("clip.x%0d", x), x, 228, x <= 16, x + 7);
    for (int x = 633; x <= 639; x++) pix_const($sformatf("nowrap.x%0d", x), x, 228, 1'b0, 0);

    // Oversize clamp and empty box
    frame(320, 240, 40, 1);
    pix_const("clamp.tl", 304, 224, 1'b1, 0);
    pix_const("clamp.br", 335, 255, 1'b1, 1023);
    pix_const("clamp.xr", 336, 240, 1'b0, 0);
    pix_const("clamp.yb", 320, 256, 1'b0, 0);
    frame(320, 240, 0, 1);
    pix_const("s0.c", 320, 240, 1'b0, 0);
    pix_const("s0.m", 319, 239, 1'b0, 0);

    // Address holds while doodle_on is low
    frame(320, 240, 12, 1);
    pix_const("hold.set", 321, 229, 1'b1, 1 * 32 + 13);
    pix_const("hold.off", 100, 100, 1'b0, 0);
    chk("hold.addr", int'(sprite_addr), 1 * 32 + 13);

    // Randomized frames, one pixel per clock, 2-clock latency
    for (int f = 0; f < 20; f++) begin
      int rx, ry, rs, rst;
      rx  = $urandom_range(0, 639);
      ry  = $urandom_range(0, 479);
      rs  = $urandom_range(0, 40);
      rst = $urandom_range(0, 2);
      frame(rx, ry, rs, rst);
      chk($sformatf("rnd%0d.face", f), int'(facing_left), int'(m_face));
      eon_q.delete(); eaddr_q.delete();
      for (int i = 0; i <= 41; i++) begin
        if (i < 40) begin
          int px, py, eaddr; bit eon;
          px = m_sx - m_ss - 2 + int'($urandom_range(0, 2 * m_ss + 4));
          py = m_sy - m_ss - 2 + int'($urandom_range(0, 2 * m_ss + 4));
          if (px < 0) px = 0;
          if (py < 0) py = 0;
          if (px > 639) px = 639;
          if (py > 479) py = 479;
          DrawX = 10'(px); DrawY = 10'(py);
          model_pix(px, py, eon, eaddr);
          eon_q.push_back(eon); eaddr_q.push_back(eaddr);
        end
        @(posedge Clk); #1;
        if (i >= 1 && eon_q.size() > 0) begin
          bit eon; int eaddr;
          eon = eon_q.pop_front(); eaddr = eaddr_q.pop_front();
          chk($sformatf("rnd%0d.p%0d.on", f, i - 1), int'(doodle_on), int'(eon));
          if (eon) chk($sformatf("rnd%0d.p%0d.addr", f, i - 1), int'(sprite_addr), eaddr);
        end
      end
    end

    // Reset mid-scan clears output immediately; centre box returns afterwards
    frame(320, 240, 12, 1);
    DrawX = 10'd320; DrawY = 10'd240;
    repeat (3) @(posedge Clk);
    #1;
    chk("midrst.pre", int'(doodle_on), 1);
    Reset = 1'b1;
    #1;
    chk("midrst.on", int'(doodle_on), 0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    model_reset();
    pix_const("postrst.c", 308, 228, 1'b1, 0);
    pix_model("postrst.m", 331, 251);
    chk("postrst.face", int'(facing_left), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
